// File: rtl/pipe_pkg.sv
// Shared pipeline payload layout: field offsets and widths, plus the standard keep masks
// used by the inter-stage registers.
package pipe_pkg;

  localparam int unsigned PAYLOAD_W    = 105;

  // Payload layout, LSB first: BD | ExcCode | ctrl | operand | PC | instr
  localparam int unsigned BD_BIT       = 0;
  localparam int unsigned EXCCODE_LSB  = 1;
  localparam int unsigned EXCCODE_SIZE = 5;
  localparam int unsigned CTRL_LSB     = 6;
  localparam int unsigned CTRL_W       = 3;
  localparam int unsigned OPND_LSB     = 9;
  localparam int unsigned OPND_W       = 32;
  localparam int unsigned PC_LSB       = 41;
  localparam int unsigned PC_W         = 32;
  localparam int unsigned INSTR_LSB    = 73;
  localparam int unsigned INSTR_W      = 32;

  typedef logic [PAYLOAD_W-1:0] payload_t;

  function automatic payload_t field_mask(input int unsigned lsb, input int unsigned width);
    payload_t m;
    m = '0;
    for (int unsigned i = 0; i < width; i++) begin
      m[lsb+i] = 1'b1;
    end
    return m;
  endfunction

  localparam payload_t KEEP_PC    = field_mask(PC_LSB, PC_W);
  localparam payload_t KEEP_PC_BD = KEEP_PC | field_mask(BD_BIT, 1);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               inc,
  output logic [COUNT_W-1:0] count
);

  localparam logic [COUNT_W-1:0] One = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + One;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, exception kill, flush-to-bubble
// with keep masks, and saturating stall/bubble counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = PAYLOAD_W,
  parameter logic [DATA_W-1:0] FLUSH_KEEP = '0,
  parameter logic [DATA_W-1:0] REQ_KEEP   = '0,
  parameter int unsigned       COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [COUNT_W-1:0] stall_cnt,
  output logic [COUNT_W-1:0] bubble_cnt
);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic              accept;
  logic              main_free;
  logic              beat_v;
  logic [DATA_W-1:0] beat_data;

  // in_ready depends only on registered state, so out_ready never reaches it combinationally
  assign in_ready  = ~skid_v_q;
  assign accept    = in_valid & in_ready;
  assign main_free = ~main_v_q | out_ready;
  assign beat_v    = ~flush;
  assign beat_data = flush ? (in_data & FLUSH_KEEP) : in_data;

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (req) begin
      main_v_d    = 1'b0;
      main_data_d = main_data_q & REQ_KEEP;
      skid_v_d    = 1'b0;
      skid_data_d = '0;
    end else if (main_free) begin
      // Skid always drains first so beat order is preserved
      if (skid_v_q) begin
        main_v_d    = 1'b1;
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
      end else if (accept) begin
        main_v_d    = beat_v;
        main_data_d = beat_data;
      end else begin
        main_v_d    = 1'b0;
      end
    end else if (accept) begin
      skid_v_d    = beat_v;
      skid_data_d = beat_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_v_q    <= 1'b0;
      main_data_q <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_valid = main_v_q;
  assign out_data  = main_data_q;

  sat_counter #(
    .COUNT_W (COUNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (main_v_q & ~out_ready & ~req),
    .count (stall_cnt)
  );

  sat_counter #(
    .COUNT_W (COUNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (accept & flush & ~req),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid; a second instance with 2-bit counters
// shares the stimulus and is checked for saturation.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned W = PAYLOAD_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  in_data;

  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [15:0]   stall_cnt, bubble_cnt;

  logic          b_in_ready, b_out_valid;
  logic [W-1:0]  b_out_data;
  logic [1:0]    b_stall_cnt, b_bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W     (W),
    .FLUSH_KEEP (KEEP_PC),
    .REQ_KEEP   (KEEP_PC_BD),
    .COUNT_W    (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  pipe_stage_skid #(
    .DATA_W  (W),
    .COUNT_W (2)
  ) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (b_in_ready),
    .in_data    (in_data),
    .out_valid  (b_out_valid),
    .out_ready  (out_ready),
    .out_data   (b_out_data),
    .stall_cnt  (b_stall_cnt),
    .bubble_cnt (b_bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
    reset = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_idle: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_stream();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = W'(i);
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== W'(i)) begin errors++;
        $display("FAIL stream_beat%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, W'(i)); end
      checks++; if (in_ready !== 1'b1) begin errors++;
        $display("FAIL stream_ready%0d: got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== W'(3)) begin errors++;
      $display("FAIL stream_drain: got v=%b d=%h want v=0 d=3", out_valid, out_data); end
    checks++; if (stall_cnt !== 16'd0) begin errors++;
      $display("FAIL stream_stall: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'hA);
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== W'(32'hA)) begin errors++;
      $display("FAIL bp_load_a: got v=%b d=%h want v=1 d=a", out_valid, out_data); end
    in_data = W'(32'hB);
    step();
    checks++; if (in_ready !== 1'b0 || out_data !== W'(32'hA)) begin errors++;
      $display("FAIL bp_skid_b: got r=%b d=%h want r=0 d=a", in_ready, out_data); end
    in_valid = 1'b0;
    step();
    checks++; if (in_ready !== 1'b0 || out_data !== W'(32'hA) || out_valid !== 1'b1) begin errors++;
      $display("FAIL bp_hold: got r=%b v=%b d=%h want r=0 v=1 d=a", in_ready, out_valid, out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== W'(32'hB) || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release_b: got v=%b d=%h r=%b want v=1 d=b r=1", out_valid, out_data, in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL bp_empty: got %b want 0", out_valid); end
    checks++; if (stall_cnt !== 16'd2) begin errors++;
      $display("FAIL bp_stall_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'h55);
    step();
    in_data = W'(32'h66);
    step();
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL rmid_full: got r=%b want 0", in_ready); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++;
      $display("FAIL rmid_main: got v=%b d=%h want v=0 d=0", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL rmid_ready: got %b want 1", in_ready); end
    checks++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin errors++;
      $display("FAIL rmid_cnt: got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL rmid_after: got v=%b want 0", out_valid); end
  endtask

  task automatic test_flush_keep();
    logic [W-1:0] beat, exp;
    beat = '0;
    beat[INSTR_LSB +: 32] = 32'hDEADBEEF;
    beat[PC_LSB +: 32]    = 32'h3000;
    beat[EXCCODE_LSB +: 5] = 5'h1F;
    beat[BD_BIT] = 1'b1;
    exp = '0;
    exp[PC_LSB +: 32] = 32'h3000;
    out_ready = 1'b1; in_valid = 1'b1; flush = 1'b1; in_data = beat;
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== exp) begin errors++;
      $display("FAIL flush_bubble: got v=%b d=%h want v=0 d=%h", out_valid, out_data, exp); end
    checks++; if (bubble_cnt !== 16'd1) begin errors++;
      $display("FAIL flush_cnt: got %0d want 1", bubble_cnt); end
    flush = 1'b0; in_data = W'(32'h7);
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== W'(32'h7)) begin errors++;
      $display("FAIL flush_overwrite: got v=%b d=%h want v=1 d=7", out_valid, out_data); end
    in_valid = 1'b1; flush = 1'b1; in_data = W'(32'h9);
    #3 in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || bubble_cnt !== 16'd1) begin errors++;
      $display("FAIL flush_noaccept: got v=%b cnt=%0d want v=0 cnt=1", out_valid, bubble_cnt); end
    flush = 1'b0;
  endtask

  task automatic test_req();
    logic [W-1:0] m, exp;
    m = '0;
    m[INSTR_LSB +: 32] = 32'h12345678;
    m[PC_LSB +: 32]    = 32'h4000;
    m[EXCCODE_LSB +: 5] = 5'h0A;
    m[BD_BIT] = 1'b1;
    exp = '0;
    exp[PC_LSB +: 32] = 32'h4000;
    exp[BD_BIT] = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = m;
    step();
    in_data = W'(32'hBEEF);
    step();
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL req_setup: got r=%b want 0", in_ready); end
    req = 1'b1; flush = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL req_kill: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    checks++; if (out_data !== exp) begin errors++;
      $display("FAIL req_keep: got %h want %h", out_data, exp); end
    checks++; if (bubble_cnt !== 16'd1 || stall_cnt !== 16'd1) begin errors++;
      $display("FAIL req_cnt: got b=%0d s=%0d want b=1 s=1", bubble_cnt, stall_cnt); end
    req = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL req_skid_gone: got v=%b want 0", out_valid); end
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'h11);
    step();
    req = 1'b1; flush = 1'b1; in_data = W'(32'h22);
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || bubble_cnt !== 16'd1) begin errors++;
      $display("FAIL req_drop_beat: got v=%b r=%b b=%0d want v=0 r=1 b=1", out_valid, in_ready,
               bubble_cnt); end
    req = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'h9);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++; if (b_stall_cnt !== 2'd3) begin errors++;
      $display("FAIL sat_stall: got %0d want 3", b_stall_cnt); end
    checks++; if (stall_cnt !== 16'd6) begin errors++;
      $display("FAIL wide_stall: got %0d want 6", stall_cnt); end
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== W'(32'h9) || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: got v=%b d=%h r=%b want v=1 d=9 r=1", b_out_valid, b_out_data,
               b_in_ready); end
    checks++; if (b_bubble_cnt !== 2'd0) begin errors++;
      $display("FAIL sat_bubble: got %0d want 0", b_bubble_cnt); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_reset_mid();
    test_flush_keep();
    test_req();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
